// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART receiver for the peripheral block (counterpart of the UART
//   transmitter). Recovers 8N1 frames, LSB first, from an asynchronous serial
//   line. The line is sampled on an OVERSAMPLE x baud tick. Good bytes go
//   into a small FIFO that the bus-side register logic pops. Framing and
//   overrun errors are reported with sticky flags.
//
// Parameters
//   OVERSAMPLE  rx_tick_i pulses per bit period (even, >= 4)
//   FIFO_AW     FIFO address width; 2**FIFO_AW slots, one always kept free
//
// Ports
//   clk_i        in   1  single clock, all logic on posedge
//   rst_i        in   1  synchronous reset, active-high
//   rx_tick_i    in   1  one-cycle pulse at OVERSAMPLE x baud
//   rx_i         in   1  serial line, asynchronous, idle high
//   re_i         in   1  pop FIFO head (ignored while empty_o=1)
//   clr_i        in   1  clear frame_err_o and overrun_o
//   data_o       out  8  FIFO head byte, valid while empty_o=0
//   empty_o      out  1  FIFO empty
//   full_o       out  1  FIFO full
//   frame_err_o  out  1  sticky: stop bit sampled low
//   overrun_o    out  1  sticky: good byte arrived while FIFO full
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_AW    = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_tick_i,
  input  logic       rx_i,
  input  logic       re_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int TW    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  // Mid-bit sample points: the start bit is qualified half a bit after the
  // falling edge. Every later sample is one full bit period after that.
  localparam logic [TW-1:0]      TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]      TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]      TICK_ONE  = TW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Sticky flag update: a set in the same cycle beats a clear.
  function automatic logic sticky_next(input logic cur, input logic set,
                                       input logic clr);
    if (set) begin
      sticky_next = 1'b1;
    end else if (clr) begin
      sticky_next = 1'b0;
    end else begin
      sticky_next = cur;
    end
  endfunction

  // -------------------------------------------------------------------------
  // Signals
  // -------------------------------------------------------------------------
  logic               rx_meta_q;
  logic               rx_s_q;

  state_e             state_q, state_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;

  logic               stop_ok;
  logic               stop_bad;
  logic               push;
  logic               pop;

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [DEPTH];

  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser. It resets to the idle level so that reset does
  // not look like a start bit.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  // The shift register is pure datapath. It only matters once eight samples
  // have been shifted in, so it needs no reset.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  // -------------------------------------------------------------------------
  // Receive FSM: next state. Everything holds between ticks.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;

    if (rx_tick_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end

        S_START: begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            if (!rx_s_q) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end else begin
              // The line came back high before mid-bit, so this was a
              // glitch. No flag is raised for it.
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        S_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        S_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            // Returning to IDLE at mid-stop lets a start bit that follows
            // back-to-back be caught on the very next tick.
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (rx_s_q) begin
              stop_ok = 1'b1;
            end else begin
              stop_bad = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        default: begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FIFO. One slot is always left free so that full and empty can be told
  // apart from the pointers alone.
  // -------------------------------------------------------------------------
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q + PTR_ONE) == rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q];

  assign push = stop_ok && !full_o;
  assign pop  = re_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset. A write during reset is harmless because the
  // pointers reset in the same cycle, so the slot counts as unread-free.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags
  // -------------------------------------------------------------------------
  always_comb begin
    frame_err_d = sticky_next(frame_err_q, stop_bad, clr_i);
    overrun_d   = sticky_next(overrun_q, stop_ok && full_o, clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Scoreboard bench for uart_rx. The stimulus side bit-bangs 8N1 frames and
//   pushes the byte each frame should deliver into a queue. A monitor pops
//   the FIFO whenever it is enabled and data is present, and compares each
//   byte against the queue head.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS        = 16;
  localparam int AW        = 5;
  localparam int CAP       = (1 << AW) - 1;
  localparam int CLK_TICK  = 4;
  localparam int BIT_CLKS  = OS * CLK_TICK;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_tick_i;
  logic       rx_i;
  logic       re_i;
  logic       clr_i;
  logic [7:0] data_o;
  logic       empty_o;
  logic       full_o;
  logic       frame_err_o;
  logic       overrun_o;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes the receiver must deliver, in order, and the
  // expected state of the sticky flags.
  logic [7:0] exp_q[$];
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;
  logic       rd_en  = 1'b0;
  logic       poke   = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .FIFO_AW(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_tick_i   (rx_tick_i),
    .rx_i        (rx_i),
    .re_i        (re_i),
    .clr_i       (clr_i),
    .data_o      (data_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock high out of every CLK_TICK.
  initial begin
    rx_tick_i = 1'b0;
    forever begin
      repeat (CLK_TICK - 1) @(posedge clk);
      #1 rx_tick_i = 1'b1;
      @(posedge clk);
      #1 rx_tick_i = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the FIFO and compares each byte against the scoreboard.
  logic [7:0] mon_exp;
  initial begin
    re_i = 1'b0;
    forever begin
      @(negedge clk);
      if (poke) begin
        re_i = 1'b1;
      end else if (rd_en && !empty_o && !rst_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_data: got unexpected byte 0x%0h required no byte", data_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_o !== mon_exp) begin
            errors++;
            $display("FAIL pop_data: got 0x%0h required 0x%0h", data_o, mon_exp);
          end
        end
        re_i = 1'b1;
      end else begin
        re_i = 1'b0;
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // Send one frame. The model decides the outcome just before the stop bit,
  // which is before the receiver samples it.
  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (stop_val) begin
      if (exp_q.size() < CAP) exp_q.push_back(d);
      else exp_ov = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
    drive_bit(stop_val);
    drive_bit(1'b1);
  endtask

  task automatic drain();
    int n;
    rd_en = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || !empty_o) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain: got %0d bytes still pending required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(posedge clk);
    #1 clr_i = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask

  logic [7:0] rb;
  logic       rs;
  logic [7:0] v55;

  initial begin
    rst_i = 1'b1;
    rx_i  = 1'b1;
    clr_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_empty", int'(empty_o), 1);
    chk("rst_full", int'(full_o), 0);
    chk("rst_frame_err", int'(frame_err_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);

    // Pop while empty must not move the pointers
    poke = 1'b1;
    repeat (2) @(posedge clk);
    #1 poke = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pop_empty_empty", int'(empty_o), 1);
    chk("pop_empty_full", int'(full_o), 0);

    // Single byte 0xA5
    send_frame(8'hA5, 1'b1);
    chk("a5_empty", int'(empty_o), 0);
    chk("a5_data", int'(data_o), 'hA5);
    chk("a5_frame_err", int'(frame_err_o), 0);
    drain();
    chk("a5_popped_empty", int'(empty_o), 1);
    rd_en = 1'b0;

    // Short low glitch on the line
    rx_i = 1'b0;
    repeat (3 * CLK_TICK) @(posedge clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("glitch_empty", int'(empty_o), 1);
    chk("glitch_frame_err", int'(frame_err_o), 0);
    chk("glitch_overrun", int'(overrun_o), 0);

    // Framing error, then clear
    send_frame(8'h3C, 1'b0);
    chk("fe_empty", int'(empty_o), 1);
    chk("fe_flag", int'(frame_err_o), int'(exp_fe));
    chk("fe_overrun", int'(overrun_o), 0);
    pulse_clr();
    chk("fe_cleared", int'(frame_err_o), int'(exp_fe));

    // Fill to capacity, then overrun
    for (int i = 0; i < CAP; i++) send_frame(8'(i), 1'b1);
    chk("fill_full", int'(full_o), 1);
    chk("fill_empty", int'(empty_o), 0);
    chk("fill_overrun", int'(overrun_o), 0);
    send_frame(8'hFF, 1'b1);
    chk("ovr_flag", int'(overrun_o), int'(exp_ov));
    chk("ovr_full", int'(full_o), 1);
    chk("ovr_frame_err", int'(frame_err_o), 0);
    drain();
    chk("ovr_drained_empty", int'(empty_o), 1);
    chk("ovr_drained_full", int'(full_o), 0);
    pulse_clr();
    chk("ovr_cleared", int'(overrun_o), 0);

    // Streaming with the reader active: pointers wrap, occupancy stays low
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1);
      chk("stream_empty", int'(empty_o), 1);
    end
    drain();
    chk("stream_overrun", int'(overrun_o), 0);
    rd_en = 1'b0;

    // Reset in the middle of the data bits of 0x55
    v55 = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v55[i]);
    rx_i = v55[4];
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    rx_i = 1'b1;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("midrst_empty", int'(empty_o), 1);
    send_frame(8'h81, 1'b1);
    chk("midrst_next_empty", int'(empty_o), 0);
    chk("midrst_next_data", int'(data_o), 'h81);
    drain();

    // Random bytes with occasional bad stop bits
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rb, rs);
    end
    drain();
    chk("rand_frame_err", int'(frame_err_o), int'(exp_fe));
    chk("rand_overrun", int'(overrun_o), int'(exp_ov));
    chk("rand_empty", int'(empty_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
